// File: rtl/otp_sequenciador_pkg.sv
// Shared types and defaults for the one-time-pad sequencer: FSM encoding and datapath sizes.
// Imported by the controller, the key bank and the bench.
package otp_sequenciador_pkg;

    localparam int LARGURA_PADRAO      = 32;
    localparam int PROFUNDIDADE_PADRAO = 8;

    typedef enum logic [1:0] {
        CARGA    = 2'd0,
        CIFRA    = 2'd1,
        ESGOTADO = 2'd2
    } estado_t;

    // Encrypt and decrypt are the same XOR; kept here so benches and datapath agree.
    function automatic logic [LARGURA_PADRAO-1:0] aplica_chave(
        input logic [LARGURA_PADRAO-1:0] palavra,
        input logic [LARGURA_PADRAO-1:0] chave
    );
        return palavra ^ chave;
    endfunction

endpackage

// File: rtl/otp_sequenciador_if.sv
// Host-side bundle of the sequencer: key load channel, message channel, result channel and status.
// master = host/source/sink side, slave = sequencer side.
interface otp_sequenciador_if #(
    parameter int LARGURA      = 32,
    parameter int PROFUNDIDADE = 8
);
    localparam int PTR_W = $clog2(PROFUNDIDADE);

    logic               recarga;
    logic [LARGURA-1:0] chave_entrada;
    logic               chave_valida;
    logic               chave_pronta;
    logic [LARGURA-1:0] mensagem;
    logic               mensagem_valida;
    logic               mensagem_pronta;
    logic [LARGURA-1:0] mensagemCifrada;
    logic               saida_valida;
    logic               saida_pronta;
    logic [PTR_W:0]     chaves_restantes;
    logic               esgotado;

    modport master (
        output recarga, chave_entrada, chave_valida, mensagem, mensagem_valida, saida_pronta,
        input  chave_pronta, mensagem_pronta, mensagemCifrada, saida_valida, chaves_restantes, esgotado
    );

    modport slave (
        input  recarga, chave_entrada, chave_valida, mensagem, mensagem_valida, saida_pronta,
        output chave_pronta, mensagem_pronta, mensagemCifrada, saida_valida, chaves_restantes, esgotado
    );

endinterface

// File: rtl/otp_sequenciador_banco_chaves.sv
// Key register file: one write port, one read port whose entry is zeroized when consumed, bulk clear.
// Read data is combinational from the addressed entry; clear wins over any same-cycle write or zeroize.
module otp_banco_chaves
    import otp_sequenciador_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter int PTR_W        = $clog2(PROFUNDIDADE)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               limpa_i,
    input  logic               esc_en_i,
    input  logic [PTR_W-1:0]   esc_ptr_i,
    input  logic [LARGURA-1:0] esc_dat_i,
    input  logic               zera_en_i,
    input  logic [PTR_W-1:0]   zera_ptr_i,
    output logic [LARGURA-1:0] lei_dat_o
);

    logic [LARGURA-1:0] banco_q [PROFUNDIDADE];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                banco_q[i] <= '0;
            end
        end else if (limpa_i) begin
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                banco_q[i] <= '0;
            end
        end else begin
            if (esc_en_i) begin
                banco_q[esc_ptr_i] <= esc_dat_i;
            end
            // A key is destroyed in the same edge that uses it.
            if (zera_en_i) begin
                banco_q[zera_ptr_i] <= '0;
            end
        end
    end

    assign lei_dat_o = banco_q[zera_ptr_i];

endmodule

// File: rtl/otp_sequenciador.sv
// One-time-pad sequencer: loads a bank of keys, XORs each accepted message word with the next unused key.
// 1-cycle latency to saida_valida, full throughput; results hold while saida_pronta is low.
module otp_sequenciador
    import otp_sequenciador_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic               clk_i,
    input  logic               rst_i,
    otp_sequenciador_if.slave  bus
);

    localparam int               PTR_W  = $clog2(PROFUNDIDADE);
    localparam logic [PTR_W-1:0] ULTIMO = PTR_W'(PROFUNDIDADE - 1);

    estado_t            estado_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     restantes_q;
    logic [LARGURA-1:0] cifrada_q;
    logic               saida_vld_q;
    logic               esgotado_q;

    logic [LARGURA-1:0] chave_lida;
    logic               chave_rdy;
    logic               msg_rdy;
    logic               chave_xfer;
    logic               msg_xfer;

    // recarga blocks both inputs so a word offered in that cycle is visibly not taken.
    assign chave_rdy  = (estado_q == CARGA) && !bus.recarga;
    assign msg_rdy    = (estado_q == CIFRA) && !bus.recarga && (!saida_vld_q || bus.saida_pronta);
    assign chave_xfer = bus.chave_valida && chave_rdy;
    assign msg_xfer   = bus.mensagem_valida && msg_rdy;

    otp_banco_chaves #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE),
        .PTR_W        (PTR_W)
    ) u_banco (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .limpa_i    (bus.recarga),
        .esc_en_i   (chave_xfer),
        .esc_ptr_i  (wr_ptr_q),
        .esc_dat_i  (bus.chave_entrada),
        .zera_en_i  (msg_xfer),
        .zera_ptr_i (rd_ptr_q),
        .lei_dat_o  (chave_lida)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            estado_q    <= CARGA;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            restantes_q <= '0;
            cifrada_q   <= '0;
            saida_vld_q <= 1'b0;
            esgotado_q  <= 1'b0;
        end else begin
            // Output register drains independently of recarga: a pending result survives a reload.
            if (msg_xfer) begin
                cifrada_q   <= bus.mensagem ^ chave_lida;
                saida_vld_q <= 1'b1;
            end else if (bus.saida_pronta) begin
                saida_vld_q <= 1'b0;
            end

            if (bus.recarga) begin
                estado_q    <= CARGA;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                restantes_q <= '0;
                esgotado_q  <= 1'b0;
            end else begin
                case (estado_q)
                    CARGA: begin
                        if (chave_xfer) begin
                            restantes_q <= restantes_q + 1'b1;
                            if (wr_ptr_q == ULTIMO) begin
                                wr_ptr_q <= '0;
                                estado_q <= CIFRA;
                            end else begin
                                wr_ptr_q <= wr_ptr_q + 1'b1;
                            end
                        end
                    end
                    CIFRA: begin
                        if (msg_xfer) begin
                            restantes_q <= restantes_q - 1'b1;
                            if (rd_ptr_q == ULTIMO) begin
                                rd_ptr_q   <= '0;
                                estado_q   <= ESGOTADO;
                                esgotado_q <= 1'b1;
                            end else begin
                                rd_ptr_q <= rd_ptr_q + 1'b1;
                            end
                        end
                    end
                    ESGOTADO: begin
                        esgotado_q <= 1'b1;
                    end
                    default: begin
                        estado_q   <= CARGA;
                        esgotado_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.chave_pronta     = chave_rdy;
    assign bus.mensagem_pronta  = msg_rdy;
    assign bus.mensagemCifrada  = cifrada_q;
    assign bus.saida_valida     = saida_vld_q;
    assign bus.chaves_restantes = restantes_q;
    assign bus.esgotado         = esgotado_q;

endmodule

// File: tb/tb_otp_sequenciador.sv
// Bench for otp_sequenciador: directed scenarios plus a random run against a queue-based key model.
module tb_otp_sequenciador;
    import otp_sequenciador_pkg::*;

    localparam int LARG = 32;
    localparam int PROF = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    otp_sequenciador_if #(.LARGURA(LARG), .PROFUNDIDADE(PROF)) bus();

    otp_sequenciador #(.LARGURA(LARG), .PROFUNDIDADE(PROF)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: unused keys in order of loading, words loaded/used in this load, output register.
    logic [31:0] m_keys[$];
    int          m_loaded;
    int          m_used;
    int          m_acc;
    bit          m_vld;
    logic [31:0] m_dat;
    bit          m_kx;
    bit          m_mx;
    logic [31:0] chaves_tb[PROF];

    function automatic bit exp_krdy();
        return !bus.recarga && (m_loaded < PROF);
    endfunction

    function automatic bit exp_mrdy();
        return !bus.recarga && (m_loaded == PROF) && (m_used < PROF) && (!m_vld || bus.saida_pronta);
    endfunction

    function automatic bit exp_esg();
        return (m_loaded == PROF) && (m_used == PROF);
    endfunction

    function automatic logic [3:0] exp_rest();
        return 4'(m_keys.size());
    endfunction

    task automatic model_reset();
        m_keys.delete();
        m_loaded = 0;
        m_used   = 0;
        m_vld    = 1'b0;
        m_dat    = '0;
    endtask

    task automatic step();
        bit krdy, mrdy;
        @(negedge clk);
        krdy = exp_krdy();
        mrdy = exp_mrdy();
        m_kx = 1'b0;
        m_mx = 1'b0;
        if (m_vld && bus.saida_pronta) m_vld = 1'b0;
        if (bus.mensagem_valida && mrdy) begin
            m_dat = bus.mensagem ^ m_keys.pop_front();
            m_vld = 1'b1;
            m_used++;
            m_acc++;
            m_mx = 1'b1;
        end
        if (bus.recarga) begin
            m_keys.delete();
            m_loaded = 0;
            m_used   = 0;
        end else if (bus.chave_valida && krdy) begin
            m_keys.push_back(bus.chave_entrada);
            m_loaded++;
            m_kx = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_recarga();
        bus.recarga = 1'b1;
        step();
        bus.recarga = 1'b0;
    endtask

    task automatic carregar(input int n);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            bus.chave_valida  = 1'b1;
            bus.chave_entrada = chaves_tb[k];
            do begin
                step();
                w++;
            end while (!m_kx && w < 20);
            if (!m_kx) begin
                total++; bad++;
                $display("FAIL key_load_timeout key=%0d not accepted in 20 cycles", k);
            end
        end
        bus.chave_valida = 1'b0;
    endtask

    task automatic enviar(input logic [31:0] msg);
        int w = 0;
        bus.mensagem_valida = 1'b1;
        bus.mensagem        = msg;
        do begin
            step();
            w++;
        end while (!m_mx && w < 20);
        if (!m_mx) begin
            total++; bad++;
            $display("FAIL msg_timeout word=%08h not accepted in 20 cycles", msg);
        end
        bus.mensagem_valida = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (bus.chaves_restantes !== 4'd0) begin bad++; $display("FAIL reset_restantes got=%0d want=0", bus.chaves_restantes); end
        total++; if (bus.saida_valida !== 1'b0) begin bad++; $display("FAIL reset_saida_valida got=%b want=0", bus.saida_valida); end
        total++; if (bus.esgotado !== 1'b0) begin bad++; $display("FAIL reset_esgotado got=%b want=0", bus.esgotado); end
        total++; if (bus.mensagemCifrada !== 32'h0) begin bad++; $display("FAIL reset_cifrada got=%08h want=0", bus.mensagemCifrada); end
        total++; if (bus.mensagem_pronta !== 1'b0) begin bad++; $display("FAIL reset_msg_pronta got=%b want=0", bus.mensagem_pronta); end
        total++; if (bus.chave_pronta !== 1'b1) begin bad++; $display("FAIL reset_chave_pronta got=%b want=1", bus.chave_pronta); end
    endtask

    task automatic test_reset_mid_load();
        logic [2:0] ix;
        for (int i = 0; i < PROF; i++) chaves_tb[i] = $urandom | 32'h1;
        carregar(3);
        total++; if (bus.chaves_restantes !== exp_rest()) begin bad++; $display("FAIL midload_restantes got=%0d want=%0d", bus.chaves_restantes, exp_rest()); end
        rst = 1'b1;
        #2;
        model_reset();
        total++; if (bus.chaves_restantes !== 4'd0) begin bad++; $display("FAIL midload_rst_restantes got=%0d want=0", bus.chaves_restantes); end
        total++; if (bus.saida_valida !== 1'b0) begin bad++; $display("FAIL midload_rst_vld got=%b want=0", bus.saida_valida); end
        for (int i = 0; i < PROF; i++) begin
            ix = i[2:0];
            total++; if (dut.u_banco.banco_q[ix] !== 32'h0) begin bad++; $display("FAIL midload_bank idx=%0d got=%08h want=0", i, dut.u_banco.banco_q[ix]); end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus.chave_pronta !== 1'b1) begin bad++; $display("FAIL midload_chave_pronta got=%b want=1", bus.chave_pronta); end
    endtask

    task automatic test_galo();
        bus.saida_pronta = 1'b1;
        for (int i = 0; i < PROF; i++) chaves_tb[i] = 32'hFFFF_FFFF;
        carregar(PROF);
        enviar(32'h6761_6C6F);
        total++; if (bus.saida_valida !== 1'b1) begin bad++; $display("FAIL galo_enc_vld got=%b want=1", bus.saida_valida); end
        total++; if (bus.mensagemCifrada !== 32'h989E_9390) begin bad++; $display("FAIL galo_enc got=%08h want=989e9390", bus.mensagemCifrada); end
        pulse_recarga();
        carregar(PROF);
        enviar(32'h989E_9390);
        total++; if (bus.mensagemCifrada !== 32'h6761_6C6F) begin bad++; $display("FAIL galo_dec got=%08h want=67616c6f", bus.mensagemCifrada); end
        total++; if (bus.chaves_restantes !== 4'd7) begin bad++; $display("FAIL galo_restantes got=%0d want=7", bus.chaves_restantes); end
    endtask

    task automatic test_exaustao();
        logic [31:0] msgs[9];
        int idx = 0;
        int vistos = 0;
        bus.saida_pronta = 1'b1;
        pulse_recarga();
        for (int i = 0; i < PROF; i++) chaves_tb[i] = $urandom;
        for (int i = 0; i < 9; i++) msgs[i] = $urandom;
        carregar(PROF);
        bus.mensagem_valida = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.mensagem = msgs[idx < 9 ? idx : 8];
            step();
            if (m_mx) idx++;
            if (bus.saida_valida) begin
                vistos++;
                total++; if (bus.mensagemCifrada !== m_dat) begin bad++; $display("FAIL exaust_word n=%0d got=%08h want=%08h", vistos, bus.mensagemCifrada, m_dat); end
            end
        end
        #1;
        total++; if (vistos !== 8) begin bad++; $display("FAIL exaust_results got=%0d want=8", vistos); end
        total++; if (bus.esgotado !== 1'b1) begin bad++; $display("FAIL exaust_esgotado got=%b want=1", bus.esgotado); end
        total++; if (bus.mensagem_pronta !== 1'b0) begin bad++; $display("FAIL exaust_msg_pronta got=%b want=0", bus.mensagem_pronta); end
        total++; if (bus.chave_pronta !== 1'b0) begin bad++; $display("FAIL exaust_chave_pronta got=%b want=0", bus.chave_pronta); end
        total++; if (bus.chaves_restantes !== 4'd0) begin bad++; $display("FAIL exaust_restantes got=%0d want=0", bus.chaves_restantes); end
        bus.mensagem_valida = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.saida_pronta = 1'b1;
        pulse_recarga();
        for (int i = 0; i < PROF; i++) chaves_tb[i] = $urandom;
        carregar(PROF);
        enviar($urandom);
        bus.saida_pronta    = 1'b0;
        bus.mensagem_valida = 1'b1;
        bus.mensagem        = $urandom;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (bus.mensagem_pronta !== 1'b0) begin bad++; $display("FAIL bp_msg_pronta cyc=%0d got=%b want=0", c, bus.mensagem_pronta); end
            step();
            total++; if (bus.mensagemCifrada !== m_dat || bus.saida_valida !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d got=%08h/%b want=%08h/1", c, bus.mensagemCifrada, bus.saida_valida, m_dat); end
            total++; if (bus.chaves_restantes !== 4'd7) begin bad++; $display("FAIL bp_restantes cyc=%0d got=%0d want=7", c, bus.chaves_restantes); end
        end
        bus.saida_pronta = 1'b1;
        step();
        bus.mensagem_valida = 1'b0;
        total++; if (bus.mensagemCifrada !== m_dat || bus.saida_valida !== 1'b1) begin bad++; $display("FAIL bp_release got=%08h/%b want=%08h/1", bus.mensagemCifrada, bus.saida_valida, m_dat); end
        total++; if (bus.chaves_restantes !== 4'd6) begin bad++; $display("FAIL bp_release_restantes got=%0d want=6", bus.chaves_restantes); end
    endtask

    task automatic test_reuso();
        logic [31:0] velhas[PROF];
        bus.saida_pronta = 1'b1;
        pulse_recarga();
        for (int i = 0; i < PROF; i++) begin
            velhas[i]    = ($urandom & 32'hFFFF_FFF0) | 32'(i);
            chaves_tb[i] = velhas[i];
        end
        carregar(PROF);
        enviar($urandom);
        enviar($urandom);
        total++; if (dut.u_banco.banco_q[0] !== 32'h0) begin bad++; $display("FAIL reuse_bank0 got=%08h want=0", dut.u_banco.banco_q[0]); end
        total++; if (dut.u_banco.banco_q[1] !== 32'h0) begin bad++; $display("FAIL reuse_bank1 got=%08h want=0", dut.u_banco.banco_q[1]); end
        total++; if (dut.u_banco.banco_q[2] !== velhas[2]) begin bad++; $display("FAIL reuse_bank2 got=%08h want=%08h", dut.u_banco.banco_q[2], velhas[2]); end
        pulse_recarga();
        for (int i = 0; i < PROF; i++) chaves_tb[i] = ~velhas[i];
        carregar(PROF);
        enviar(32'h0);
        total++; if (bus.mensagemCifrada !== ~velhas[0]) begin bad++; $display("FAIL reuse_newkey got=%08h want=%08h", bus.mensagemCifrada, ~velhas[0]); end
        for (int i = 0; i < PROF; i++) begin
            total++; if (bus.mensagemCifrada === velhas[i]) begin bad++; $display("FAIL reuse_oldkey idx=%0d got=%08h want=not old key", i, bus.mensagemCifrada); end
        end
    endtask

    task automatic test_recarga_mesmo_ciclo();
        int acc_antes;
        bus.saida_pronta = 1'b1;
        pulse_recarga();
        for (int i = 0; i < PROF; i++) chaves_tb[i] = $urandom;
        carregar(PROF);
        bus.saida_pronta = 1'b0;
        enviar($urandom);
        acc_antes           = m_acc;
        bus.recarga         = 1'b1;
        bus.mensagem_valida = 1'b1;
        bus.mensagem        = $urandom;
        #1;
        total++; if (bus.mensagem_pronta !== 1'b0) begin bad++; $display("FAIL sameclk_msg_pronta got=%b want=0", bus.mensagem_pronta); end
        step();
        bus.recarga         = 1'b0;
        bus.mensagem_valida = 1'b0;
        #1;
        total++; if (m_acc !== acc_antes) begin bad++; $display("FAIL sameclk_model_acc got=%0d want=%0d", m_acc, acc_antes); end
        total++; if (bus.chave_pronta !== 1'b1) begin bad++; $display("FAIL sameclk_carga got=%b want=1", bus.chave_pronta); end
        total++; if (bus.chaves_restantes !== 4'd0) begin bad++; $display("FAIL sameclk_restantes got=%0d want=0", bus.chaves_restantes); end
        total++; if (bus.saida_valida !== 1'b1 || bus.mensagemCifrada !== m_dat) begin bad++; $display("FAIL sameclk_pending got=%08h/%b want=%08h/1", bus.mensagemCifrada, bus.saida_valida, m_dat); end
        bus.saida_pronta = 1'b1;
        step();
        total++; if (bus.saida_valida !== 1'b0) begin bad++; $display("FAIL sameclk_drain got=%b want=0", bus.saida_valida); end
    endtask

    task automatic test_aleatorio();
        bus.saida_pronta = 1'b1;
        pulse_recarga();
        for (int c = 0; c < 600; c++) begin
            bus.recarga      = ($urandom_range(0, 39) == 0);
            bus.saida_pronta = ($urandom_range(0, 9) < 6);
            if (!bus.chave_valida || m_kx) begin
                bus.chave_valida  = ($urandom_range(0, 9) < 7);
                bus.chave_entrada = $urandom;
            end
            if (!bus.mensagem_valida || m_mx) begin
                bus.mensagem_valida = ($urandom_range(0, 9) < 7);
                bus.mensagem        = $urandom;
            end
            #1;
            total++; if (bus.chave_pronta !== exp_krdy()) begin bad++; $display("FAIL rnd_chave_pronta cyc=%0d got=%b want=%b", c, bus.chave_pronta, exp_krdy()); end
            total++; if (bus.mensagem_pronta !== exp_mrdy()) begin bad++; $display("FAIL rnd_msg_pronta cyc=%0d got=%b want=%b", c, bus.mensagem_pronta, exp_mrdy()); end
            step();
            total++; if (bus.saida_valida !== m_vld) begin bad++; $display("FAIL rnd_vld cyc=%0d got=%b want=%b", c, bus.saida_valida, m_vld); end
            if (m_vld) begin
                total++; if (bus.mensagemCifrada !== m_dat) begin bad++; $display("FAIL rnd_dat cyc=%0d got=%08h want=%08h", c, bus.mensagemCifrada, m_dat); end
            end
            total++; if (bus.chaves_restantes !== exp_rest()) begin bad++; $display("FAIL rnd_restantes cyc=%0d got=%0d want=%0d", c, bus.chaves_restantes, exp_rest()); end
            total++; if (bus.esgotado !== exp_esg()) begin bad++; $display("FAIL rnd_esgotado cyc=%0d got=%b want=%b", c, bus.esgotado, exp_esg()); end
        end
        bus.recarga         = 1'b0;
        bus.chave_valida    = 1'b0;
        bus.mensagem_valida = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.recarga         = 1'b0;
        bus.chave_entrada   = '0;
        bus.chave_valida    = 1'b0;
        bus.mensagem        = '0;
        bus.mensagem_valida = 1'b0;
        bus.saida_pronta    = 1'b0;
        m_acc = 0;
        m_kx  = 1'b0;
        m_mx  = 1'b0;
        model_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset_mid_load();
        test_galo();
        test_exaustao();
        test_backpressure();
        test_reuso();
        test_recarga_mesmo_ciclo();
        test_aleatorio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
